// File: rtl/cfu_cmd_issuer.sv
// Queues CFU commands, issues them one at a time, and collects each response
// (or a timeout marker when the CFU stays silent) into a response FIFO.
module cfu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [9:0]  push_function_id,
    input  logic [31:0] push_in0,
    input  logic [31:0] push_in1,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        rsp_ready,
    output logic        pop_valid,
    input  logic        pop_ready,
    output logic [31:0] pop_data,
    output logic        pop_timeout,
    output logic        busy
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    typedef struct packed {
        logic [9:0]  function_id;
        logic [31:0] in0;
        logic [31:0] in1;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        timeout;
    } rsp_t;

    cmd_t          cmd_mem [DEPTH];
    logic [AW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [AW:0]   cmd_count;
    rsp_t          rsp_mem [DEPTH];
    logic [AW-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [AW:0]   rsp_count;

    state_t      state, state_next;
    logic [15:0] timer, timer_next;
    logic        push_fire, cmd_fire, pop_fire, rsp_write;
    rsp_t        rsp_wdata;
    cmd_t        cmd_head;
    rsp_t        rsp_head;

    assign cmd_head = cmd_mem[cmd_rd_ptr];
    assign rsp_head = rsp_mem[rsp_rd_ptr];

    // Handshake outputs are forced to their idle values while reset is held.
    assign push_ready = reset || (cmd_count != FULL_COUNT);
    assign push_fire  = push_valid && push_ready && !reset;
    assign cmd_valid  = !reset && (state == ISSUE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rsp_ready  = !reset && (state == WAIT_RSP);
    assign pop_valid  = !reset && (rsp_count != '0);
    assign pop_fire   = pop_valid && pop_ready;
    assign busy       = !reset && ((state != IDLE) || (cmd_count != '0));

    assign cmd_payload_function_id = cmd_valid ? cmd_head.function_id : '0;
    assign cmd_payload_inputs_0    = cmd_valid ? cmd_head.in0 : '0;
    assign cmd_payload_inputs_1    = cmd_valid ? cmd_head.in1 : '0;
    assign pop_data                = pop_valid ? rsp_head.data : '0;
    assign pop_timeout             = pop_valid && rsp_head.timeout;

    // NOTE: storage arrays are not reset; the counts gate every read path, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_fire) cmd_mem[cmd_wr_ptr] <= {push_function_id, push_in0, push_in1};
        if (rsp_write) rsp_mem[rsp_wr_ptr] <= rsp_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (push_fire) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_fire)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (rsp_write) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (pop_fire)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            cmd_count <= cmd_count + (AW + 1)'(push_fire) - (AW + 1)'(cmd_fire);
            rsp_count <= rsp_count + (AW + 1)'(rsp_write) - (AW + 1)'(pop_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        timer_next = timer;
        rsp_write  = 1'b0;
        rsp_wdata  = '0;
        case (state)
            IDLE: begin
                // Only one command is ever outstanding, so a slot checked here stays free.
                if ((cmd_count != '0) && (rsp_count < FULL_COUNT)) state_next = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    timer_next = '0;
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    rsp_write  = 1'b1;
                    rsp_wdata  = '{data: rsp_payload_outputs_0, timeout: 1'b0};
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    rsp_write  = 1'b1;
                    rsp_wdata  = '{data: 32'h0, timeout: 1'b1};
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/cfu_cmd_issuer.md
CFU_CMD_ISSUER -- requirements
Module: cfu_cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4: entries in each of the command FIFO and the response FIFO (power of two, at least 2).
REQ-002 Parameter TIMEOUT, default 255: cycles spent in WAIT_RSP before the response is declared lost (1..65535).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 push_valid  in  1  command-side producer offers a command.
REQ-006 push_ready  out  1  command FIFO not full.
REQ-007 push_function_id  in  10  function id; bits [9:3] are funct7.
REQ-008 push_in0, push_in1  in  32 each  operand payloads.
REQ-009 cmd_valid  out  1  command presented to the CFU.
REQ-010 cmd_ready  in  1  CFU accepts the command.
REQ-011 cmd_payload_function_id  out  10; cmd_payload_inputs_0, cmd_payload_inputs_1  out  32 each.
REQ-012 rsp_valid  in  1; rsp_payload_outputs_0  in  32; rsp_ready  out  1.
REQ-013 pop_valid  out  1  response FIFO not empty.
REQ-014 pop_ready  in  1  consumer takes the head response.
REQ-015 pop_data  out  32; pop_timeout  out  1: the head entry was produced by a timeout.
REQ-016 busy  out  1  high when the FSM is not IDLE or the command FIFO is not empty.

Function
REQ-017 A push SHALL occur on any cycle where push_valid && push_ready; the entry {function_id, in0, in1} is appended to the command FIFO.
REQ-018 A pop SHALL occur on any cycle where pop_valid && pop_ready; pop_data and pop_timeout show the head entry combinationally.
REQ-019 Simultaneous push and pop on the same FIFO SHALL both take effect, including when that FIFO is full or empty, with the occupancy count unchanged; a push to a full FIFO cannot occur because push_ready is 0.
REQ-020 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RSP; only one command is outstanding at a time.
REQ-021 IDLE -> ISSUE SHALL happen when the command FIFO is not empty and (response-FIFO occupancy + 0) < DEPTH; a free response slot is reserved before issue.
REQ-022 In ISSUE, cmd_valid SHALL be 1 and the cmd_payload_* outputs SHALL equal the command-FIFO head and stay stable until accepted.
REQ-023 On a cycle with cmd_valid && cmd_ready, the FSM SHALL pop the command FIFO, clear the timer to 0 and move to WAIT_RSP; cmd_valid SHALL never drop without an acceptance.
REQ-024 In WAIT_RSP, rsp_ready SHALL be 1; rsp_ready SHALL be 0 in all other states.
REQ-025 In WAIT_RSP with rsp_valid = 1, the FSM SHALL write {rsp_payload_outputs_0, timeout = 0} to the response FIFO and return to IDLE.
REQ-026 In WAIT_RSP with rsp_valid = 0, the timer SHALL increment each cycle.
REQ-027 If the timer reaches TIMEOUT-1 while rsp_valid = 0, the FSM SHALL write {32'h0, timeout = 1} and return to IDLE.
REQ-028 If rsp_valid arrives on the same cycle the timeout fires, the response SHALL take priority and be stored with timeout = 0.
REQ-029 A rsp_valid received outside WAIT_RSP SHALL be ignored (rsp_ready is 0 there).
REQ-030 Minimum throughput SHALL be one command per 3 cycles: ISSUE accept, response in WAIT_RSP, then IDLE.
REQ-031 The timer SHALL be 16 bits wide; FIFO pointers SHALL wrap modulo DEPTH; occupancy counters SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-032 On reset the FSM SHALL go to IDLE and both FIFOs SHALL be emptied, including mid-transaction.
REQ-033 On reset the timer SHALL be cleared to 0.
REQ-034 During and after reset, cmd_valid, rsp_ready, pop_valid and busy SHALL be 0 and push_ready SHALL be 1.
REQ-035 cmd_payload_*, pop_data and pop_timeout SHALL be 0 after reset.
REQ-036 An outstanding CFU response arriving after reset SHALL be dropped.

Verification
REQ-037 Single command: push fid=0x008, in0=5, in1=7; the CFU accepts immediately and returns 0x0000000C one cycle later -> cmd_valid high for exactly 1 cycle, pop_data=0x0000000C, pop_timeout=0.
REQ-038 Backpressure: cmd_ready held 0 for 10 cycles -> cmd_valid and the payload stay stable all 10 cycles and the command is issued exactly once.
REQ-039 Timeout: TIMEOUT=8 and the CFU never responds -> exactly 8 cycles in WAIT_RSP, then entry {0, timeout=1} is stored and the next command issues.
REQ-040 Full response FIFO: 5 commands pushed with pop_ready=0 and DEPTH=4 -> 4 responses stored, the 5th command stays in IDLE unissued; one pop -> the 5th command issues.
REQ-041 Reset mid-operation: reset asserted in WAIT_RSP with 2 commands queued -> next cycle all outputs are at reset values and a late rsp_valid is ignored.
REQ-042 Response/timeout collision: rsp_valid=1 on the cycle the timer hits TIMEOUT-1 with payload 0xDEADBEEF -> stored entry is 0xDEADBEEF with timeout=0.
